ascon_serial_bridge: RTL and testbench

Parametrised byte-serial front end for the Ascon-128 AEAD core. It packs narrow pin-level bytes into wide key, nonce and data words, and presents data words to the core over a valid/ready stream. It unpacks core output blocks and the final tag back into bytes under host flow control. Optionally it verifies a host-loaded expected tag. It replaces the fixed 8-bit pin-level shift logic of the TinyTapeout tile and is reusable at other IO, block and key widths.

---
 rtl/ascon_serial_bridge.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ascon_serial_bridge.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_serial_bridge.sv
// Byte-serial host front end for an Ascon-128 AEAD core: packs key/nonce/data/tag bytes,
// streams data blocks to the core and serializes output blocks and the tag. Option: SERIAL_TAG_VERIFY_EN.
module ascon_serial_bridge #(
   parameter int unsigned IO_W  = 8,
   parameter int unsigned KEY_W = 128,
   parameter int unsigned BLK_W = 64,
   parameter int unsigned TAG_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_cmd,
   input  logic [IO_W-1:0]    in_byte,
   input  logic               in_last,
   input  logic               start,
   input  logic               decrypt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IO_W-1:0]    out_byte,
   output logic               out_is_tag,
   output logic [KEY_W-1:0]   key,
   output logic [KEY_W-1:0]   nonce,
   output logic               start_enc,
   output logic               start_dec,
   input  logic               core_busy,
   output logic               s_valid,
   input  logic               s_ready,
   output logic [BLK_W-1:0]   s_data,
   output logic               s_last,
   input  logic               m_valid,
   output logic               m_ready,
   input  logic [BLK_W-1:0]   m_data,
   input  logic               tag_valid,
   input  logic [TAG_W-1:0]   core_tag,
   output logic               proto_err,
   output logic               auth_fail
);

   localparam int unsigned KB  = KEY_W / IO_W;
   localparam int unsigned BPB = BLK_W / IO_W;
   localparam int unsigned TB  = TAG_W / IO_W;
   localparam int unsigned KCW = (KB > 1) ? $clog2(KB) : 1;
   localparam int unsigned DCW = (BPB > 1) ? $clog2(BPB) : 1;
   localparam int unsigned OSW = (TAG_W > BLK_W) ? TAG_W : BLK_W;
   localparam int unsigned OB  = (TB > BPB) ? TB : BPB;
   localparam int unsigned OCW = (OB > 1) ? $clog2(OB) : 1;

   localparam logic [1:0] CMD_KEY   = 2'b00;
   localparam logic [1:0] CMD_NONCE = 2'b01;
   localparam logic [1:0] CMD_DATA  = 2'b10;
   localparam logic [1:0] CMD_TAG   = 2'b11;

   typedef enum logic [1:0] {O_IDLE, O_DATA, O_TAG} ostate_e;

   logic [KEY_W-1:0] key_q, nonce_q;
   logic [KCW-1:0]   key_cnt_q, nonce_cnt_q;
   logic [BLK_W-1:0] data_sh_q, s_data_q;
   logic [DCW-1:0]   data_cnt_q;
   logic [1:0]       last_cmd_q;
   logic             s_valid_q, s_last_q, proto_err_q;
   logic             start_enc_q, start_dec_q;
   logic             in_acc, start_ok, prev_cnt_nz;

`ifdef SERIAL_TAG_VERIFY_EN
   localparam int unsigned TCW = (TB > 1) ? $clog2(TB) : 1;
   logic [TAG_W-1:0] exp_tag_q;
   logic [TCW-1:0]   tag_cnt_q;
   logic             dec_sess_q, auth_fail_q;
`endif

   assign in_ready = (in_cmd == CMD_DATA) ? !s_valid_q : !core_busy;
   assign in_acc   = in_valid && in_ready;
   assign start_ok = start && !core_busy;

   // Whether the field last written still holds a partial value
   always_comb begin
      prev_cnt_nz = 1'b0;
      case (last_cmd_q)
         CMD_KEY:   prev_cnt_nz = (key_cnt_q != '0);
         CMD_NONCE: prev_cnt_nz = (nonce_cnt_q != '0);
         CMD_DATA:  prev_cnt_nz = (data_cnt_q != '0);
`ifdef SERIAL_TAG_VERIFY_EN
         CMD_TAG:   prev_cnt_nz = (tag_cnt_q != '0);
`endif
         default:   prev_cnt_nz = 1'b0;
      endcase
   end

   // Input packing, block hand-off to the core and session control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q       <= '0;
         nonce_q     <= '0;
         key_cnt_q   <= '0;
         nonce_cnt_q <= '0;
         data_sh_q   <= '0;
         s_data_q    <= '0;
         data_cnt_q  <= '0;
         last_cmd_q  <= CMD_KEY;
         s_valid_q   <= 1'b0;
         s_last_q    <= 1'b0;
         proto_err_q <= 1'b0;
         start_enc_q <= 1'b0;
         start_dec_q <= 1'b0;
`ifdef SERIAL_TAG_VERIFY_EN
         exp_tag_q   <= '0;
         tag_cnt_q   <= '0;
         dec_sess_q  <= 1'b0;
         auth_fail_q <= 1'b0;
`endif
      end else begin
         start_enc_q <= start_ok && !decrypt;
         start_dec_q <= start_ok && decrypt;
         if (s_valid_q && s_ready) s_valid_q <= 1'b0;
         if (start_ok) begin
            key_cnt_q   <= '0;
            nonce_cnt_q <= '0;
            data_cnt_q  <= '0;
            proto_err_q <= 1'b0;
`ifdef SERIAL_TAG_VERIFY_EN
            tag_cnt_q   <= '0;
            dec_sess_q  <= decrypt;
`endif
         end else if (in_acc) begin
            last_cmd_q <= in_cmd;
            if ((in_cmd != last_cmd_q) && prev_cnt_nz) begin
               proto_err_q <= 1'b1;
               case (last_cmd_q)
                  CMD_KEY:   key_cnt_q   <= '0;
                  CMD_NONCE: nonce_cnt_q <= '0;
                  CMD_DATA:  data_cnt_q  <= '0;
`ifdef SERIAL_TAG_VERIFY_EN
                  CMD_TAG:   tag_cnt_q   <= '0;
`endif
                  default:   ;
               endcase
            end
            case (in_cmd)
               CMD_KEY: begin
                  key_q     <= {key_q[KEY_W-IO_W-1:0], in_byte};
                  key_cnt_q <= (key_cnt_q == KCW'(KB-1)) ? '0 : key_cnt_q + KCW'(1);
               end
               CMD_NONCE: begin
                  nonce_q     <= {nonce_q[KEY_W-IO_W-1:0], in_byte};
                  nonce_cnt_q <= (nonce_cnt_q == KCW'(KB-1)) ? '0 : nonce_cnt_q + KCW'(1);
               end
               CMD_DATA: begin
                  data_sh_q <= {data_sh_q[BLK_W-IO_W-1:0], in_byte};
                  if (data_cnt_q == DCW'(BPB-1)) begin
                     s_data_q   <= {data_sh_q[BLK_W-IO_W-1:0], in_byte};
                     s_valid_q  <= 1'b1;
                     s_last_q   <= in_last;
                     data_cnt_q <= '0;
                  end else if (in_last) begin
                     proto_err_q <= 1'b1;
                     data_cnt_q  <= '0;
                  end else begin
                     data_cnt_q <= data_cnt_q + DCW'(1);
                  end
               end
               default: begin
`ifdef SERIAL_TAG_VERIFY_EN
                  exp_tag_q <= {exp_tag_q[TAG_W-IO_W-1:0], in_byte};
                  tag_cnt_q <= (tag_cnt_q == TCW'(TB-1)) ? '0 : tag_cnt_q + TCW'(1);
`else
                  proto_err_q <= 1'b1;
`endif
               end
            endcase
         end
`ifdef SERIAL_TAG_VERIFY_EN
         if (start_ok) auth_fail_q <= 1'b0;
         else if (tag_valid && dec_sess_q && (core_tag != exp_tag_q)) auth_fail_q <= 1'b1;
`endif
      end
   end

   assign key       = key_q;
   assign nonce     = nonce_q;
   assign s_valid   = s_valid_q;
   assign s_data    = s_data_q;
   assign s_last    = s_last_q;
   assign proto_err = proto_err_q;
   assign start_enc = start_enc_q;
   assign start_dec = start_dec_q;
`ifdef SERIAL_TAG_VERIFY_EN
   assign auth_fail = auth_fail_q;
`else
   assign auth_fail = 1'b0;
`endif

   ostate_e          state_q, state_d;
   logic [OSW-1:0]   out_sh_q, out_sh_d;
   logic [OCW-1:0]   out_cnt_q, out_cnt_d;
   logic [TAG_W-1:0] tag_buf_q, tag_buf_d;
   logic             tag_pend_q, tag_pend_d;

   assign m_ready = m_valid && (state_q == O_IDLE) && !tag_pend_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= O_IDLE;
         out_sh_q   <= '0;
         out_cnt_q  <= '0;
         tag_buf_q  <= '0;
         tag_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_sh_q   <= out_sh_d;
         out_cnt_q  <= out_cnt_d;
         tag_buf_q  <= tag_buf_d;
         tag_pend_q <= tag_pend_d;
      end
   end

   // Output serializer; data always drains before a pending tag
   always_comb begin
      state_d    = state_q;
      out_sh_d   = out_sh_q;
      out_cnt_d  = out_cnt_q;
      tag_buf_d  = tag_buf_q;
      tag_pend_d = tag_pend_q;
      case (state_q)
         O_IDLE: begin
            if (m_ready) begin
               out_sh_d  = OSW'(m_data) << (OSW - BLK_W);
               out_cnt_d = '0;
               state_d   = O_DATA;
            end else if (tag_pend_q || tag_valid) begin
               out_sh_d  = OSW'(tag_pend_q ? tag_buf_q : core_tag) << (OSW - TAG_W);
               out_cnt_d = '0;
               state_d   = O_TAG;
            end
         end
         O_DATA: begin
            if (out_ready) begin
               out_sh_d = out_sh_q << IO_W;
               if (out_cnt_q == OCW'(BPB-1)) begin
                  out_cnt_d = '0;
                  state_d   = O_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + OCW'(1);
               end
            end
         end
         O_TAG: begin
            if (out_ready) begin
               out_sh_d = out_sh_q << IO_W;
               if (out_cnt_q == OCW'(TB-1)) begin
                  out_cnt_d  = '0;
                  state_d    = O_IDLE;
                  tag_pend_d = 1'b0;
               end else begin
                  out_cnt_d = out_cnt_q + OCW'(1);
               end
            end
         end
         default: state_d = O_IDLE;
      endcase
      if (tag_valid) begin
         tag_pend_d = 1'b1;
         tag_buf_d  = core_tag;
      end
      if (start_ok) begin
         state_d    = O_IDLE;
         out_cnt_d  = '0;
         tag_pend_d = 1'b0;
      end
   end

   assign out_valid  = (state_q != O_IDLE);
   assign out_is_tag = (state_q == O_TAG);
   assign out_byte   = out_sh_q[OSW-1 -: IO_W];

endmodule

// File: tb/tb_ascon_serial_bridge.sv
// Self-checking bench for ascon_serial_bridge with a queue-based model of byte packing and output order.
module tb_ascon_serial_bridge;

   logic         clk, rst_n;
   logic         in_valid, in_ready, in_last, start, decrypt;
   logic [1:0]   in_cmd;
   logic [7:0]   in_byte, out_byte;
   logic         out_valid, out_ready, out_is_tag;
   logic [127:0] key, nonce, core_tag;
   logic         start_enc, start_dec, core_busy;
   logic         s_valid, s_ready, s_last, m_valid, m_ready, tag_valid;
   logic [63:0]  s_data, m_data;
   logic         proto_err, auth_fail;

   int checks = 0;
   int errors = 0;
   logic [8:0] got[$];
   logic [8:0] expq[$];

   ascon_serial_bridge #(.IO_W(8), .KEY_W(128), .BLK_W(64), .TAG_W(128)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_byte(in_byte), .in_last(in_last), .start(start), .decrypt(decrypt),
      .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_is_tag(out_is_tag),
      .key(key), .nonce(nonce), .start_enc(start_enc), .start_dec(start_dec), .core_busy(core_busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .tag_valid(tag_valid),
      .core_tag(core_tag), .proto_err(proto_err), .auth_fail(auth_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called just after a falling edge; returns at the falling edge after the byte was taken
   task automatic send_byte(input logic [1:0] c, input logic [7:0] b, input bit l);
      int n = 0;
      in_valid = 1'b1; in_cmd = c; in_byte = b; in_last = l;
      #1;
      while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
      checks++;
      if (n >= 200) begin errors++; $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_field(input logic [1:0] c, input logic [127:0] v);
      for (int i = 0; i < 16; i++) send_byte(c, v[(15-i)*8 +: 8], 1'b0);
   endtask

   task automatic pulse_start(input bit dec);
      start = 1'b1; decrypt = dec;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [127:0] v, input int nbytes, input bit is_tag);
      for (int i = 0; i < nbytes; i++) expq.push_back({is_tag, v[(nbytes-1-i)*8 +: 8]});
   endtask

   task automatic collect(input int n, input bit toggle);
      int cyc = 0;
      got.delete();
      while (got.size() < n && cyc < 2000) begin
         @(negedge clk);
         out_ready = toggle ? cyc[0] : 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) got.push_back({out_is_tag, out_byte});
         cyc++;
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic compare_out(input string name);
      checks++;
      if (got.size() != expq.size()) begin
         errors++; $display("FAIL %s_count: got %0d bytes required %0d", name, got.size(), expq.size());
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            errors++; $display("FAIL %s_byte%0d: got tag/byte %h required %h", name, i, got[i], expq[i]);
         end
      end
      expq.delete();
   endtask

   // Push one block through the packer and release it with s_ready after a random stall
   task automatic do_block(input logic [63:0] v, input bit last);
      int d;
      for (int i = 0; i < 8; i++) send_byte(2'b10, v[(7-i)*8 +: 8], last && (i == 7));
      #1;
      checks++;
      if ({s_valid, s_data, s_last} !== {1'b1, v, last}) begin
         errors++; $display("FAIL block_out: s_valid=%b s_data=%h s_last=%b required 1 %h %b", s_valid, s_data, s_last, v, last);
      end
      d = $urandom_range(1, 3);
      repeat (d) begin
         in_cmd = 2'b10; #1;
         checks++;
         if ({in_ready, s_valid} !== 2'b01) begin
            errors++; $display("FAIL block_hold: in_ready=%b s_valid=%b required 0 1", in_ready, s_valid);
         end
         @(negedge clk);
      end
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0; #1;
      checks++;
      if ({s_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL block_release: s_valid=%b in_ready=%b required 0 1", s_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({in_ready, out_valid, out_byte, out_is_tag, s_valid, s_last, s_data, m_ready, start_enc, start_dec}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_byte=%h s_valid=%b s_data=%h required 1 0 00 0 0",
                            in_ready, out_valid, out_byte, s_valid, s_data);
      end
      checks++;
      if ({key, nonce, proto_err, auth_fail} !== 258'h0) begin
         errors++; $display("FAIL reset_regs: key=%h nonce=%h proto_err=%b auth_fail=%b required all 0", key, nonce, proto_err, auth_fail);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_key_nonce;
      logic [127:0] nv;
      nv = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 16; i++) send_byte(2'b00, 8'(i), 1'b0);
      send_field(2'b01, nv);
      #1;
      checks++;
      if (key !== 128'h000102030405060708090A0B0C0D0E0F) begin
         errors++; $display("FAIL key_load: key=%h required 000102030405060708090a0b0c0d0e0f", key);
      end
      checks++;
      if ({nonce, proto_err} !== {nv, 1'b0}) begin
         errors++; $display("FAIL nonce_load: nonce=%h proto_err=%b required %h 0", nonce, proto_err, nv);
      end
   endtask

   task automatic test_stream;
      do_block(64'h1112131415161718, 1'b0);
      do_block(64'h2122232425262728, 1'b1);
      for (int k = 0; k < 4; k++) do_block({$urandom, $urandom}, 1'($urandom_range(0, 1)));
   endtask

   task automatic test_proto_err;
      send_byte(2'b10, 8'h31, 1'b0);
      send_byte(2'b10, 8'h32, 1'b0);
      send_byte(2'b10, 8'h33, 1'b1);
      repeat (2) begin
         #1;
         checks++;
         if ({proto_err, s_valid} !== 2'b10) begin
            errors++; $display("FAIL early_last: proto_err=%b s_valid=%b required 1 0", proto_err, s_valid);
         end
         @(negedge clk);
      end
      pulse_start(1'b0);
      #1;
      checks++;
      if ({start_enc, start_dec, proto_err} !== 3'b100) begin
         errors++; $display("FAIL start_clear: start_enc=%b start_dec=%b proto_err=%b required 1 0 0", start_enc, start_dec, proto_err);
      end
      @(negedge clk); #1;
      checks++;
      if ({start_enc, start_dec} !== 2'b00) begin
         errors++; $display("FAIL start_width: start_enc=%b start_dec=%b required 0 0", start_enc, start_dec);
      end
      do_block({$urandom, $urandom}, 1'b0);
   endtask

   task automatic test_cmd_change;
      logic [127:0] k0;
      k0 = key;
      send_byte(2'b00, 8'hC1, 1'b0);
      send_byte(2'b00, 8'hC2, 1'b0);
      #1;
      checks++;
      if ({key, proto_err} !== {k0[111:0], 8'hC1, 8'hC2, 1'b0}) begin
         errors++; $display("FAIL key_partial: key=%h proto_err=%b required %h 0", key, proto_err, {k0[111:0], 16'hC1C2});
      end
      send_byte(2'b01, 8'h5A, 1'b0);
      #1;
      checks++;
      if ({proto_err, nonce[7:0]} !== {1'b1, 8'h5A}) begin
         errors++; $display("FAIL cmd_change: proto_err=%b nonce_lsb=%h required 1 5a", proto_err, nonce[7:0]);
      end
      pulse_start(1'b0);
      @(negedge clk);
`ifndef SERIAL_TAG_VERIFY_EN
      send_byte(2'b11, 8'h77, 1'b0);
      #1;
      checks++;
      if ({proto_err, auth_fail} !== 2'b10) begin
         errors++; $display("FAIL tag_cmd_disabled: proto_err=%b auth_fail=%b required 1 0", proto_err, auth_fail);
      end
      pulse_start(1'b0);
      @(negedge clk);
`endif
   endtask

   task automatic test_busy;
      core_busy = 1'b1; in_cmd = 2'b00; #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_key: in_ready=%b required 0", in_ready); end
      in_cmd = 2'b10; #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_data: in_ready=%b required 1", in_ready); end
      pulse_start(1'b1);
      #1;
      checks++;
      if ({start_enc, start_dec} !== 2'b00) begin
         errors++; $display("FAIL busy_start: start_enc=%b start_dec=%b required 0 0", start_enc, start_dec);
      end
      core_busy = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [63:0] b2;
      b2 = {$urandom, $urandom};
      push_exp(128'(64'hA1A2A3A4A5A6A7A8), 8, 1'b0);
      push_exp(128'(b2), 8, 1'b0);
      fork
         collect(16, 1'b1);
         begin
            int n = 0;
            m_valid = 1'b1; m_data = 64'hA1A2A3A4A5A6A7A8; #1;
            while (!m_ready && n < 100) begin @(negedge clk); #1; n++; end
            @(negedge clk);
            m_data = b2; #1;
            checks++;
            if (m_ready !== 1'b0) begin errors++; $display("FAIL m_ready_pulse: m_ready=%b required 0", m_ready); end
            n = 0;
            while (!m_ready && n < 500) begin @(negedge clk); #1; n++; end
            checks++;
            if (got.size() != 8) begin
               errors++; $display("FAIL second_block_wait: bytes out=%0d required 8", got.size());
            end
            @(negedge clk);
            m_valid = 1'b0;
         end
      join
      compare_out("backpressure");
   endtask

   task automatic test_tag_during_data;
      logic [63:0]  d;
      logic [127:0] t;
      d = {$urandom, $urandom};
      t = {$urandom, $urandom, $urandom, $urandom};
      push_exp(128'(d), 8, 1'b0);
      push_exp(t, 16, 1'b1);
      fork
         collect(24, 1'b0);
         begin
            int n = 0;
            m_valid = 1'b1; m_data = d; #1;
            while (!m_ready && n < 100) begin @(negedge clk); #1; n++; end
            @(negedge clk);
            m_valid = 1'b0; tag_valid = 1'b1; core_tag = t;
            @(negedge clk);
            tag_valid = 1'b0;
         end
      join
      compare_out("tag_after_data");
   endtask

   task automatic test_tag_idle;
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      tag_valid = 1'b1; core_tag = t;
      @(negedge clk);
      tag_valid = 1'b0; #1;
      checks++;
      if ({out_valid, out_is_tag, out_byte} !== {2'b11, t[127:120]}) begin
         errors++; $display("FAIL tag_latency: out_valid=%b out_is_tag=%b out_byte=%h required 1 1 %h", out_valid, out_is_tag, out_byte, t[127:120]);
      end
      push_exp(t, 16, 1'b1);
      collect(16, 1'b0);
      compare_out("tag_idle");
   endtask

   task automatic test_start_abort;
      int n = 0;
      m_valid = 1'b1; m_data = {$urandom, $urandom}; #1;
      while (!m_ready && n < 100) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      m_valid = 1'b0; #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre: out_valid=%b required 1", out_valid); end
      pulse_start(1'b1);
      #1;
      checks++;
      if ({out_valid, start_dec, start_enc} !== 3'b010) begin
         errors++; $display("FAIL abort: out_valid=%b start_dec=%b start_enc=%b required 0 1 0", out_valid, start_dec, start_enc);
      end
      @(negedge clk);
   endtask

`ifdef SERIAL_TAG_VERIFY_EN
   task automatic test_auth;
      logic [127:0] e;
      e = {$urandom, $urandom, $urandom, $urandom};
      send_field(2'b11, e);
      pulse_start(1'b1);
      @(negedge clk);
      tag_valid = 1'b1; core_tag = e ^ 128'h1;
      @(negedge clk);
      tag_valid = 1'b0; #1;
      checks++;
      if (auth_fail !== 1'b1) begin errors++; $display("FAIL auth_mismatch: auth_fail=%b required 1", auth_fail); end
      collect(16, 1'b0);
      pulse_start(1'b1);
      #1;
      checks++;
      if (auth_fail !== 1'b0) begin errors++; $display("FAIL auth_clear: auth_fail=%b required 0", auth_fail); end
      @(negedge clk);
      tag_valid = 1'b1; core_tag = e;
      @(negedge clk);
      tag_valid = 1'b0; #1;
      checks++;
      if (auth_fail !== 1'b0) begin errors++; $display("FAIL auth_match: auth_fail=%b required 0", auth_fail); end
      collect(16, 1'b0);
   endtask
`endif

   task automatic test_reset_mid;
      send_byte(2'b10, 8'h01, 1'b0);
      send_byte(2'b10, 8'h02, 1'b0);
      send_byte(2'b10, 8'h03, 1'b0);
      rst_n = 1'b0; #1;
      checks++;
      if ({key, nonce, s_valid, out_valid, proto_err} !== 259'h0) begin
         errors++; $display("FAIL reset_mid: key=%h s_valid=%b out_valid=%b required 0 0 0", key, s_valid, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_block({$urandom, $urandom}, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_cmd = 2'b00; in_byte = 8'h00; in_last = 1'b0;
      start = 1'b0; decrypt = 1'b0; out_ready = 1'b0; core_busy = 1'b0; s_ready = 1'b0;
      m_valid = 1'b0; m_data = '0; tag_valid = 1'b0; core_tag = '0;
      test_reset();
      test_key_nonce();
      test_stream();
      test_proto_err();
      test_cmd_change();
      test_busy();
      test_backpressure();
      test_tag_during_data();
      test_tag_idle();
      test_start_abort();
`ifdef SERIAL_TAG_VERIFY_EN
      test_auth();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
